fetch_stage: RTL and testbench



---
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bundle between the fetch stage
// (master) and instruction memory (slave).
interface fetch_stage_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  imem_req;
    logic [WORD_WIDTH-1:0] imem_addr;
    logic                  imem_ack;
    logic [WORD_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake with
// wait states, and drives the IF/ID register with freeze hold and branch flush.
module fetch_stage #(
    parameter int                    WORD_WIDTH = 32,
    parameter logic [WORD_WIDTH-1:0] RESET_PC   = {WORD_WIDTH{1'b0}},
    parameter logic [WORD_WIDTH-1:0] PC_INC     = {{(WORD_WIDTH-3){1'b0}}, 3'd4}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [WORD_WIDTH-1:0] branch_addr,
    fetch_stage_if.master         imem,
    output logic [WORD_WIDTH-1:0] pc_out,
    output logic [WORD_WIDTH-1:0] instruction_out,
    output logic                  valid_out,
    output logic [31:0]           fetch_count
);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    function automatic logic [WORD_WIDTH-1:0] pc_next(input logic [WORD_WIDTH-1:0] pc);
        return pc + PC_INC;
    endfunction

    state_t                state_r,       state_s;
    logic [WORD_WIDTH-1:0] pc_r,          pc_s;
    logic [WORD_WIDTH-1:0] pc_out_r,      pc_out_s;
    logic [WORD_WIDTH-1:0] instr_out_r,   instr_out_s;
    logic                  valid_out_r,   valid_out_s;
    logic [31:0]           fetch_count_r, fetch_count_s;
    logic [WORD_WIDTH-1:0] hold_pc_r,     hold_pc_s;
    logic [WORD_WIDTH-1:0] hold_instr_r,  hold_instr_s;

    // Request is suppressed while held and during reset so memory never sees a stale PC.
    assign imem.imem_req  = (state_r == ST_FETCH) && !rst;
    assign imem.imem_addr = pc_r;

    assign pc_out          = pc_out_r;
    assign instruction_out = instr_out_r;
    assign valid_out       = valid_out_r;
    assign fetch_count     = fetch_count_r;

    // State, PC, IF/ID and hold-buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_FETCH;
            pc_r          <= RESET_PC;
            pc_out_r      <= {WORD_WIDTH{1'b0}};
            instr_out_r   <= {WORD_WIDTH{1'b0}};
            valid_out_r   <= 1'b0;
            fetch_count_r <= 32'd0;
            hold_pc_r     <= {WORD_WIDTH{1'b0}};
            hold_instr_r  <= {WORD_WIDTH{1'b0}};
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            pc_out_r      <= pc_out_s;
            instr_out_r   <= instr_out_s;
            valid_out_r   <= valid_out_s;
            fetch_count_r <= fetch_count_s;
            hold_pc_r     <= hold_pc_s;
            hold_instr_r  <= hold_instr_s;
        end
    end

    // Next-state logic: branch beats freeze, freeze beats normal fetch.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        pc_out_s      = pc_out_r;
        instr_out_s   = instr_out_r;
        valid_out_s   = valid_out_r;
        fetch_count_s = fetch_count_r;
        hold_pc_s     = hold_pc_r;
        hold_instr_s  = hold_instr_r;

        if (branch_taken) begin
            // A same-cycle ack belongs to the wrong path and is dropped.
            state_s      = ST_FETCH;
            pc_s         = branch_addr;
            pc_out_s     = {WORD_WIDTH{1'b0}};
            instr_out_s  = {WORD_WIDTH{1'b0}};
            valid_out_s  = 1'b0;
            hold_pc_s    = {WORD_WIDTH{1'b0}};
            hold_instr_s = {WORD_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (imem.imem_ack) begin
                        if (freeze) begin
                            hold_pc_s    = pc_next(pc_r);
                            hold_instr_s = imem.imem_rdata;
                            state_s      = ST_HOLD;
                        end else begin
                            pc_out_s      = pc_next(pc_r);
                            instr_out_s   = imem.imem_rdata;
                            valid_out_s   = 1'b1;
                            pc_s          = pc_next(pc_r);
                            fetch_count_s = fetch_count_r + 32'd1;
                        end
                    end else begin
                        if (freeze) begin
                            state_s = ST_FETCH;
                        end else begin
                            instr_out_s = {WORD_WIDTH{1'b0}};
                            valid_out_s = 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (freeze) begin
                        state_s = ST_HOLD;
                    end else begin
                        pc_out_s      = hold_pc_r;
                        instr_out_s   = hold_instr_r;
                        valid_out_s   = 1'b1;
                        pc_s          = pc_next(pc_r);
                        fetch_count_s = fetch_count_r + 32'd1;
                        state_s       = ST_FETCH;
                    end
                end
                default: begin
                    state_s = ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns addr|0xE000_0000, ack and
// freeze are driven step by step, expected values are hand-computed constants.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = 32'd0;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;
    logic [31:0] fetch_count;

    int passed = 0;
    int total  = 0;

    fetch_stage_if #(.WORD_WIDTH(32)) ifc ();

    assign ifc.imem_rdata = ifc.imem_addr | 32'hE000_0000;

    fetch_stage #(.WORD_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .imem            (ifc.master),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                              input logic vld, input logic [31:0] cnt);
        check({tag, ".pc_out"}, pc_out, pc);
        check({tag, ".instr"}, instruction_out, ins);
        check({tag, ".valid"}, {31'd0, valid_out}, {31'd0, vld});
        check({tag, ".count"}, fetch_count, cnt);
    endtask

    initial begin
        ifc.imem_ack = 1'b0;

        // Reset values
        tick();
        check_ifid("reset", 32'd0, 32'd0, 1'b0, 32'd0);
        check("reset.addr", ifc.imem_addr, 32'd0);
        check("reset.req", {31'd0, ifc.imem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel.req", {31'd0, ifc.imem_req}, 32'd1);

        // 1: zero-wait back-to-back fetches
        ifc.imem_ack = 1'b1;
        tick(); check_ifid("seq0", 32'd4,  32'hE000_0000, 1'b1, 32'd1);
        tick(); check_ifid("seq1", 32'd8,  32'hE000_0004, 1'b1, 32'd2);
        tick(); check_ifid("seq2", 32'd12, 32'hE000_0008, 1'b1, 32'd3);
        tick(); check_ifid("seq3", 32'd16, 32'hE000_000C, 1'b1, 32'd4);
        check("seq.addr", ifc.imem_addr, 32'd16);

        // 2: redirect to 8, then two wait states
        ifc.imem_ack = 1'b0;
        branch_taken = 1'b1; branch_addr = 32'd8;
        tick(); check_ifid("br8", 32'd0, 32'd0, 1'b0, 32'd4);
        check("br8.addr", ifc.imem_addr, 32'd8);
        branch_taken = 1'b0;
        tick(); check("wait1.addr", ifc.imem_addr, 32'd8);
        check("wait1.valid", {31'd0, valid_out}, 32'd0);
        tick(); check("wait2.addr", ifc.imem_addr, 32'd8);
        check("wait2.valid", {31'd0, valid_out}, 32'd0);
        ifc.imem_ack = 1'b1;
        tick(); check_ifid("wait.ack", 32'd12, 32'hE000_0008, 1'b1, 32'd5);
        check("wait.addr", ifc.imem_addr, 32'd12);

        // 3: fetch at 0, then freeze on the ack for PC=4
        ifc.imem_ack = 1'b0;
        branch_taken = 1'b1; branch_addr = 32'd0;
        tick();
        branch_taken = 1'b0; ifc.imem_ack = 1'b1;
        tick(); check_ifid("f0", 32'd4, 32'hE000_0000, 1'b1, 32'd6);
        freeze = 1'b1;
        tick(); check_ifid("hold1", 32'd4, 32'hE000_0000, 1'b1, 32'd6);
        check("hold1.req", {31'd0, ifc.imem_req}, 32'd0);
        check("hold1.addr", ifc.imem_addr, 32'd4);
        ifc.imem_ack = 1'b0;
        tick(); check_ifid("hold2", 32'd4, 32'hE000_0000, 1'b1, 32'd6);
        tick(); check_ifid("hold3", 32'd4, 32'hE000_0000, 1'b1, 32'd6);
        check("hold3.req", {31'd0, ifc.imem_req}, 32'd0);
        freeze = 1'b0;
        tick(); check_ifid("unhold", 32'd8, 32'hE000_0004, 1'b1, 32'd7);
        check("unhold.addr", ifc.imem_addr, 32'd8);
        check("unhold.req", {31'd0, ifc.imem_req}, 32'd1);

        // 4: branch wins over simultaneous ack and freeze
        branch_taken = 1'b1; branch_addr = 32'h100; ifc.imem_ack = 1'b1; freeze = 1'b1;
        tick(); check_ifid("brpri", 32'd0, 32'd0, 1'b0, 32'd7);
        check("brpri.addr", ifc.imem_addr, 32'h100);
        check("brpri.req", {31'd0, ifc.imem_req}, 32'd1);
        branch_taken = 1'b0; freeze = 1'b0; ifc.imem_ack = 1'b0;

        // 5: asynchronous reset while waiting at PC=0x20
        branch_taken = 1'b1; branch_addr = 32'h1C;
        tick();
        branch_taken = 1'b0; ifc.imem_ack = 1'b1;
        tick(); check_ifid("f1c", 32'h20, 32'hE000_001C, 1'b1, 32'd8);
        ifc.imem_ack = 1'b0;
        tick(); check_ifid("w20", 32'h20, 32'd0, 1'b0, 32'd8);
        check("w20.addr", ifc.imem_addr, 32'h20);
        #2 rst = 1'b1;
        #1;
        check_ifid("arst", 32'd0, 32'd0, 1'b0, 32'd0);
        check("arst.addr", ifc.imem_addr, 32'd0);
        check("arst.req", {31'd0, ifc.imem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0; ifc.imem_ack = 1'b1;
        tick(); check_ifid("postrst", 32'd4, 32'hE000_0000, 1'b1, 32'd1);

        // 6: PC wraps from 0xFFFF_FFFC to 0
        ifc.imem_ack = 1'b0;
        branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
        tick(); check("wrap.addr0", ifc.imem_addr, 32'hFFFF_FFFC);
        branch_taken = 1'b0; ifc.imem_ack = 1'b1;
        tick(); check_ifid("wrap", 32'd0, 32'hFFFF_FFFC, 1'b1, 32'd2);
        check("wrap.addr1", ifc.imem_addr, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
